ram_bist_ctrl: RTL and testbench
================================

// Module: ram_bist_ctrl
// PURPOSE
//  Memory-test initiator for the 32-bit req/we/be/addr/wdata -> rvalid/rdata RAM port.
//  Drives a RAM port directly, in place of the core.
//  On start it runs a 4-phase march over Depth words:
//    W0: write P(i). R0: read/check P(i). W1: write ~P(i). R1: read/check ~P(i).
//  Reports done, pass/fail and the first failing address.
// PARAMETERS
//  Depth     128           words tested (>=2); index width Iw = $clog2(Depth)
//  BaseAddr  32'h0         byte address of word 0; word i at BaseAddr + 4*i (mod 2^32)
//  Seed      32'hA5A5_5A5A pattern seed; P(i) = Seed ^ {{(32-Iw){1'b0}}, i}
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   reset, asynchronous, active-low
//  start_i       in   1   start pulse; sampled only in IDLE
//  busy_o        out  1   test in progress
//  done_o        out  1   test finished; held until next start
//  pass_o        out  1   valid when done_o; 1 = no mismatch
//  err_addr_o    out  32  byte address of first mismatch; 0 if none
//  req_o         out  1   memory request
//  we_o          out  1   1 = write, 0 = read
//  be_o          out  4   byte enables; 4'hF whenever req_o, else 4'h0
//  addr_o        out  32  byte address, word aligned
//  wdata_o       out  32  write data; 0 on reads
//  rvalid_i      in   1   read/write response; one per accepted req, in order
//  rdata_i       in   32  read data; qualified by rvalid_i on reads
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE, counters/FIFO cleared.
//  Request handshake:
//   - No grant. Every cycle with req_o=1 is one accepted request.
//   - Responder returns rvalid_i >=1 cycle later, in order (ram_2p: exactly 1).
//  Outstanding count:
//   - Incremented on each req_o, decremented on each rvalid_i.
//   - Max 2; req_o is held 0 while the count is 2.
//   - Write responses are counted but not checked.
//  Expected-data FIFO:
//   - 2 entries; each read req pushes {expected data, addr}.
//   - Each read rvalid_i pops one entry and compares against rdata_i.
//  Back-to-back issue: with a 1-cycle responder, one request per cycle, no bubbles.
//  States:
//   IDLE  : start_i=1 -> W0. Same edge: i=0, clear done_o/pass_o/err_addr_o, busy_o=1.
//   W0    : write P(i), i++ per request. Request for i=Depth-1 issued -> R0, i=0.
//   R0    : read, expect P(i). Last request issued -> W1, i=0.
//   W1    : write ~P(i). Last request issued -> R1, i=0.
//   R1    : read, expect ~P(i). Last request issued -> DRAIN.
//   DRAIN : no req. Outstanding==0 -> DONE.
//   DONE  : done_o=1, busy_o=0. pass_o=1 iff no mismatch. Then -> IDLE; outputs held.
//  Phase changes carry outstanding responses across; the FIFO keeps checks correct.
//  Mismatch handling:
//   - Mismatch = rdata_i != expected on a read response.
//   - First mismatch latches err_addr_o and clears the pass flag.
//   - Later mismatches do not overwrite err_addr_o. The test always runs to completion.
//  Boundary conditions:
//   - start_i while busy: ignored.
//   - rvalid_i with outstanding==0: ignored, count does not underflow (assertion flags it).
//   - i wraps at Depth-1 -> 0 on phase change only.
//   - Address arithmetic is 32-bit, wrapping.
//   - Reset mid-test: async return to IDLE. req_o drops immediately.
//     In-flight responses after reset are ignored (outstanding==0).
//  Latency: Depth=N with a 1-cycle responder -> done_o rises 4N+2 cycles after start_i.
// CONFIGURATION
//  RAM_BIST_ERR_CNT_EN defined:
//   - Extra port err_cnt_o (out, 16), reset 0, cleared on start.
//   - Increments per mismatch, saturates at 16'hFFFF.
//  RAM_BIST_ERR_CNT_EN undefined: port absent, no counter logic.
//  All other behaviour identical.
// TESTING
//  1. ram_2p model, Depth=16, start pulse.
//     -> 64 reqs in order W0,R0,W1,R1; done_o=1 at cycle 66; pass_o=1; err_addr_o=0.
//  2. Model forces word 5 bit 0 stuck-at-1, Seed=32'hA5A5_5A5A.
//     -> pass_o=0, err_addr_o=32'h14; err_cnt_o=1 if enabled.
//  3. Responder delays rvalid_i 3 cycles.
//     -> never >2 outstanding; checks still in order; pass_o=1.
//  4. start_i pulsed again at cycle 10 of a run -> ignored; run completes normally.
//  5. rst_ni low mid-R0 -> all outputs 0 same cycle; new start gives a clean passing run.
//  6. BaseAddr=32'hFFFF_FFF8, Depth=4 -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4; pass_o=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bist_ctrl
//  Purpose  : March-style memory test initiator for a 32-bit req/we/be/addr/
//             wdata -> rvalid/rdata RAM port. It runs four phases over Depth
//             words: W0 write P(i), R0 read/check P(i), W1 write ~P(i),
//             R1 read/check ~P(i). It reports done, pass/fail and the first
//             failing byte address.
//  Ports    : clk_i, rst_ni (async, active-low), start_i
//             busy_o, done_o, pass_o, err_addr_o[31:0]   - status
//             req_o, we_o, be_o[3:0], addr_o[31:0], wdata_o[31:0] - RAM request
//             rvalid_i, rdata_i[31:0]                     - RAM response
//             err_cnt_o[15:0]  (only when RAM_BIST_ERR_CNT_EN is defined)
//  Options  : RAM_BIST_ERR_CNT_EN - adds a saturating mismatch counter.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_bist_ctrl #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter logic [31:0] Seed     = 32'hA5A5_5A5A
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] err_addr_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
`ifdef RAM_BIST_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int unsigned   Iw      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Iw-1:0] LastIdx = Iw'(Depth - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_R0    = 3'd2,
    S_W1    = 3'd3,
    S_R1    = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [Iw-1:0]   idx_q, idx_d;
  logic [1:0]      outst_q;
  logic            done_q;
  logic            ok_q;        // no mismatch seen yet in this run
  logic [31:0]     err_addr_q;

  // In-order tracker of outstanding requests. Every request is pushed so
  // write responses can be told apart from read responses; only read
  // entries are checked.
  logic            fifo_rd_q   [2];
  logic [31:0]     fifo_exp_q  [2];
  logic [31:0]     fifo_addr_q [2];
  logic            wr_ptr_q, rd_ptr_q;

  logic            w_start, w_active, w_req, w_write, w_inv, w_rsp, w_mismatch;
  logic [31:0]     w_pat, w_data, w_addr;

  assign w_start  = (state_q == S_IDLE) && start_i;
  assign w_active = (state_q == S_W0) || (state_q == S_R0) ||
                    (state_q == S_W1) || (state_q == S_R1);
  assign w_req    = w_active && (outst_q != 2'd2);
  assign w_write  = (state_q == S_W0) || (state_q == S_W1);
  assign w_inv    = (state_q == S_W1) || (state_q == S_R1);
  assign w_pat    = Seed ^ 32'(idx_q);
  assign w_data   = w_inv ? ~w_pat : w_pat;
  assign w_addr   = BaseAddr + (32'(idx_q) << 2);

  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign w_rsp      = rvalid_i && (outst_q != 2'd0);
  assign w_mismatch = w_rsp && fifo_rd_q[rd_ptr_q] && (rdata_i != fifo_exp_q[rd_ptr_q]);

  assign req_o      = w_req;
  assign we_o       = w_req && w_write;
  assign be_o       = w_req ? 4'hF : 4'h0;
  assign addr_o     = w_req ? w_addr : 32'h0;
  assign wdata_o    = (w_req && w_write) ? w_data : 32'h0;
  assign busy_o     = w_active || (state_q == S_DRAIN);
  assign done_o     = done_q;
  assign pass_o     = done_q && ok_q;
  assign err_addr_o = err_addr_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_W0;
          idx_d   = '0;
        end
      end
      S_W0, S_R0, S_W1, S_R1: begin
        if (w_req) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            case (state_q)
              S_W0:    state_d = S_R0;
              S_R0:    state_d = S_W1;
              S_W1:    state_d = S_R1;
              default: state_d = S_DRAIN;
            endcase
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == 2'd0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outstanding count and expected-data tracker
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        fifo_rd_q[k]   <= 1'b0;
        fifo_exp_q[k]  <= 32'h0;
        fifo_addr_q[k] <= 32'h0;
      end
    end else begin
      if (w_req && !w_rsp)      outst_q <= outst_q + 2'd1;
      else if (!w_req && w_rsp) outst_q <= outst_q - 2'd1;
      if (w_req) begin
        fifo_rd_q[wr_ptr_q]   <= !w_write;
        fifo_exp_q[wr_ptr_q]  <= w_data;
        fifo_addr_q[wr_ptr_q] <= w_addr;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (w_rsp) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // --------------------------------------------------------------------------
  // Result tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      if (w_start) begin
        done_q     <= 1'b0;
        ok_q       <= 1'b1;
        err_addr_q <= 32'h0;
      end else begin
        if ((state_q == S_DRAIN) && (outst_q == 2'd0)) done_q <= 1'b1;
        // ok_q doubles as the "first mismatch" flag so later ones keep the address.
        if (w_mismatch && ok_q) begin
          ok_q       <= 1'b0;
          err_addr_q <= fifo_addr_q[rd_ptr_q];
        end
      end
    end
  end

`ifdef RAM_BIST_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'h0;
    end else if (w_start) begin
      err_cnt_q <= 16'h0;
    end else if (w_mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   rvalid_i |-> (outst_q != 2'd0));
  a_outst_max:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   outst_q <= 2'd2);

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_bist_ctrl
//  Purpose  : Self-checking bench for ram_bist_ctrl. Instance 1 (Depth=16,
//             base 0) sits on a RAM model with selectable response latency and
//             an optional stuck-at-1 fault on word 5 bit 0. Instance 2
//             (Depth=4, base 32'hFFFF_FFF8) checks address wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bist_ctrl;

  localparam int          N1    = 16;
  localparam int          N2    = 4;
  localparam logic [31:0] SEED  = 32'hA5A5_5A5A;
  localparam logic [31:0] BASE2 = 32'hFFFF_FFF8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int nvec  = 0;
  int nfail = 0;

  // ---------------- DUT 1 ----------------
  logic        start1 = 1'b0;
  logic        busy1, done1, pass1, req1, we1, rvalid1;
  logic [3:0]  be1;
  logic [31:0] err1, addr1, wdata1, rdata1;
`ifdef RAM_BIST_ERR_CNT_EN
  logic [15:0] errcnt1, errcnt2;
`endif

  ram_bist_ctrl #(.Depth(N1), .BaseAddr(32'h0), .Seed(SEED)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_addr_o(err1),
    .req_o(req1), .we_o(we1), .be_o(be1), .addr_o(addr1), .wdata_o(wdata1),
    .rvalid_i(rvalid1), .rdata_i(rdata1)
`ifdef RAM_BIST_ERR_CNT_EN
    , .err_cnt_o(errcnt1)
`endif
  );

  // RAM model 1: latency 1..3, optional stuck-at-1 on word 5 bit 0
  int          lat   = 1;
  logic        fault = 1'b0;
  logic [31:0] mem1 [N1];
  logic [3:1]  pv1 = '0;
  logic [31:0] pd1 [1:3];

  always @(posedge clk_i) begin
    pv1    <= {pv1[2:1], req1};
    pd1[1] <= (fault && addr1[5:2] == 4'd5) ? (mem1[addr1[5:2]] | 32'h1) : mem1[addr1[5:2]];
    pd1[2] <= pd1[1];
    pd1[3] <= pd1[2];
    if (req1 && we1) mem1[addr1[5:2]] <= wdata1;
  end
  assign rvalid1 = pv1[lat];
  assign rdata1  = pd1[lat];

  // Request logger / outstanding tracker 1
  int          k1 = 0, out1 = 0, maxout1 = 0;
  logic        we_log1   [64];
  logic [3:0]  be_log1   [64];
  logic [31:0] addr_log1 [64];
  logic [31:0] wd_log1   [64];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      k1 <= 0; out1 <= 0; maxout1 <= 0;
    end else begin
      if (start1 && !busy1) begin
        k1 <= 0; maxout1 <= 0;
      end else if (req1) begin
        if (k1 < 64) begin
          we_log1[k1] <= we1; be_log1[k1] <= be1; addr_log1[k1] <= addr1; wd_log1[k1] <= wdata1;
        end
        k1 <= k1 + 1;
        if (out1 + 1 > maxout1) maxout1 <= out1 + 1;
      end
      out1 <= out1 + int'(req1) - int'(rvalid1 && out1 > 0);
    end
  end

  // ---------------- DUT 2 ----------------
  logic        start2 = 1'b0;
  logic        busy2, done2, pass2, req2, we2, rvalid2;
  logic [3:0]  be2;
  logic [31:0] err2, addr2, wdata2, rdata2;

  ram_bist_ctrl #(.Depth(N2), .BaseAddr(BASE2), .Seed(SEED)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_addr_o(err2),
    .req_o(req2), .we_o(we2), .be_o(be2), .addr_o(addr2), .wdata_o(wdata2),
    .rvalid_i(rvalid2), .rdata_i(rdata2)
`ifdef RAM_BIST_ERR_CNT_EN
    , .err_cnt_o(errcnt2)
`endif
  );

  logic [31:0] mem2 [N2];
  logic        pv2 = 1'b0;
  logic [31:0] pd2;
  always @(posedge clk_i) begin
    pv2 <= req2;
    pd2 <= mem2[addr2[3:2]];
    if (req2 && we2) mem2[addr2[3:2]] <= wdata2;
  end
  assign rvalid2 = pv2;
  assign rdata2  = pd2;

  int          k2 = 0;
  logic        we_log2   [16];
  logic [3:0]  be_log2   [16];
  logic [31:0] addr_log2 [16];
  logic [31:0] wd_log2   [16];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      k2 <= 0;
    end else if (start2 && !busy2) begin
      k2 <= 0;
    end else if (req2) begin
      if (k2 < 16) begin
        we_log2[k2] <= we2; be_log2[k2] <= be2; addr_log2[k2] <= addr2; wd_log2[k2] <= wdata2;
      end
      k2 <= k2 + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected request number k of a march over n words starting at base.
  function automatic logic [95:0] exp_req(input int k, input int n, input logic [31:0] base);
    int          ph, i;
    logic [31:0] p, a, wd;
    logic        w;
    ph = k / n;
    i  = k % n;
    p  = SEED ^ 32'(i);
    a  = base + 32'(4 * i);
    w  = (ph == 0) || (ph == 2);
    wd = (ph == 0) ? p : (ph == 2) ? ~p : 32'h0;
    return {27'h0, w, 4'hF, a, wd};
  endfunction

  task automatic check_log(input int which);
    for (int k = 0; k < ((which == 1) ? 4 * N1 : 4 * N2); k++) begin
      if (which == 1)
        chk($sformatf("req1[%0d]", k), {27'h0, we_log1[k], be_log1[k], addr_log1[k], wd_log1[k]},
            exp_req(k, N1, 32'h0));
      else
        chk($sformatf("req2[%0d]", k), {27'h0, we_log2[k], be_log2[k], addr_log2[k], wd_log2[k]},
            exp_req(k, N2, BASE2));
    end
  endtask

  task automatic run1(input int restart_at, output int cyc);
    @(negedge clk_i); start1 = 1'b1;
    @(negedge clk_i); start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
      start1 = (cyc == restart_at);
    end
    start1 = 1'b0;
  endtask

  typedef struct {
    int          lat;
    logic        fault;
    int          restart_at;
    int          exp_cyc;
    logic        exp_pass;
    logic [31:0] exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;

    vecs[0] = '{lat:1, fault:1'b0, restart_at:0,  exp_cyc:66,  exp_pass:1'b1, exp_err:32'h0,  exp_cnt:16'd0};
    vecs[1] = '{lat:1, fault:1'b1, restart_at:0,  exp_cyc:66,  exp_pass:1'b0, exp_err:32'h14, exp_cnt:16'd1};
    vecs[2] = '{lat:3, fault:1'b0, restart_at:0,  exp_cyc:130, exp_pass:1'b1, exp_err:32'h0,  exp_cnt:16'd0};
    vecs[3] = '{lat:1, fault:1'b0, restart_at:10, exp_cyc:66,  exp_pass:1'b1, exp_err:32'h0,  exp_cnt:16'd0};
    vecs[4] = '{lat:2, fault:1'b1, restart_at:0,  exp_cyc:98,  exp_pass:1'b0, exp_err:32'h14, exp_cnt:16'd1};

    // Reset state
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset_status", 96'({busy1, done1, pass1, err1}), 96'h0);
    chk("reset_req",    {27'h0, req1, be1, addr1, wdata1}, 96'h0);
    chk("reset_we",     96'(we1), 96'h0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Table-driven full runs
    for (int v = 0; v < 5; v++) begin
      lat   = vecs[v].lat;
      fault = vecs[v].fault;
      run1(vecs[v].restart_at, cyc);
      chk($sformatf("v%0d done_cycle", v), 96'(cyc), 96'(vecs[v].exp_cyc));
      chk($sformatf("v%0d pass", v),       96'(pass1), 96'(vecs[v].exp_pass));
      chk($sformatf("v%0d err_addr", v),   96'(err1), 96'(vecs[v].exp_err));
`ifdef RAM_BIST_ERR_CNT_EN
      chk($sformatf("v%0d err_cnt", v),    96'(errcnt1), 96'(vecs[v].exp_cnt));
`endif
      chk($sformatf("v%0d req_count", v),  96'(k1), 96'(4 * N1));
      chk($sformatf("v%0d outst<=2", v),   96'(maxout1 <= 2), 96'(1));
      check_log(1);
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d held", v), 96'({done1, busy1, pass1}), 96'({1'b1, 1'b0, vecs[v].exp_pass}));
    end

    // Reset in the middle of R0, then a clean run
    lat = 1; fault = 1'b0;
    @(negedge clk_i); start1 = 1'b1;
    @(negedge clk_i); start1 = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("midrun_active", 96'({busy1, req1, we1}), 96'({1'b1, 1'b1, 1'b0}));
    rst_ni = 1'b0;
    #1;
    chk("rst_status", 96'({busy1, done1, pass1, err1}), 96'h0);
    chk("rst_req",    {27'h0, req1, be1, addr1, wdata1}, 96'h0);
    chk("rst_we",     96'(we1), 96'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    run1(0, cyc);
    chk("post_rst done_cycle", 96'(cyc), 96'(66));
    chk("post_rst pass",       96'({pass1, err1}), 96'({1'b1, 32'h0}));
    chk("post_rst req_count",  96'(k1), 96'(4 * N1));
    check_log(1);

    // Address wrap: Depth=4 at 32'hFFFF_FFF8
    @(negedge clk_i); start2 = 1'b1;
    @(negedge clk_i); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("wrap done_cycle", 96'(cyc), 96'(4 * N2 + 2));
    chk("wrap pass",       96'({pass2, err2}), 96'({1'b1, 32'h0}));
    chk("wrap req_count",  96'(k2), 96'(4 * N2));
    chk("wrap addr2",      96'(addr_log2[2]), 96'h0);
    chk("wrap addr0",      96'(addr_log2[0]), 96'hFFFF_FFF8);
    check_log(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
